// File: rtl/mdu_div.sv
// Multi-cycle 32-bit radix-2 restoring divider (DIV when SIGNED=1, DIVU when SIGNED=0).
// Accepts operands on a valid/ready handshake and returns {remainder, quotient} 34 cycles later.
module mdu_div #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid_i,
  input  logic [31:0] div_opr1_i,
  input  logic [31:0] div_opr2_i,
  input  logic        div_flush_i,
  output logic        div_rdy_o,
  output logic [63:0] div_data_o,
  output logic        div_ansok_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] rq;
  logic [31:0] dmag;
  logic [31:0] opr1_q;
  logic        qsign, rsign, dz;

  logic        accept;
  logic [31:0] mag1, mag2;
  logic [33:0] trial;
  logic [63:0] step;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] result;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    div_rdy_o   = 1'b0;
    div_ansok_o = 1'b0;
    case (state)
      IDLE: begin
        div_rdy_o = 1'b1;
        accept    = div_valid_i;
        if (div_valid_i) state_nxt = CALC;
      end
      CALC: if (cnt == 6'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        div_rdy_o   = 1'b1;
        div_ansok_o = 1'b1;
        accept      = div_valid_i;
        state_nxt   = div_valid_i ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush wins over a new start and over completion.
    if (div_flush_i) begin
      state_nxt = IDLE;
      accept    = 1'b0;
    end
  end

  always_comb begin
    mag1 = (SIGNED && div_opr1_i[31]) ? (~div_opr1_i + 32'd1) : div_opr1_i;
    mag2 = (SIGNED && div_opr2_i[31]) ? (~div_opr2_i + 32'd1) : div_opr2_i;

    // Upper 33 bits of the shifted register minus the divisor; bit 33 is the borrow.
    trial = {1'b0, rq[63:31]} - {2'b00, dmag};
    step  = trial[33] ? {rq[62:0], 1'b0} : {trial[31:0], rq[30:0], 1'b1};

    quo_fix = qsign ? (~rq[31:0] + 32'd1) : rq[31:0];
    rem_fix = rsign ? (~rq[63:32] + 32'd1) : rq[63:32];
    result  = dz ? {opr1_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      div_data_o <= 64'h0;
    end else begin
      state <= state_nxt;
      if (accept)              cnt <= 6'd0;
      else if (state == CALC)  cnt <= cnt + 6'd1;
      if (state == FIX && !div_flush_i) div_data_o <= result;
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      rq     <= {32'h0, mag1};
      dmag   <= mag2;
      opr1_q <= div_opr1_i;
      qsign  <= SIGNED && (div_opr1_i[31] ^ div_opr2_i[31]);
      rsign  <= SIGNED && div_opr1_i[31];
      dz     <= (div_opr2_i == 32'h0);
    end else if (state == CALC) begin
      rq <= step;
    end
  end

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: a signed and an unsigned instance share stimulus and are
// compared against an arithmetic reference model cycle by cycle.
module tb_mdu_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        flush;
  logic [31:0] opr1, opr2;
  logic        rdy_s, ansok_s, rdy_u, ansok_u;
  logic [63:0] data_s, data_u;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] last_s   = 64'h0;
  logic [63:0] last_u   = 64'h0;

  always #5 clk = ~clk;

  mdu_div #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .div_valid_i(valid), .div_opr1_i(opr1), .div_opr2_i(opr2),
    .div_flush_i(flush), .div_rdy_o(rdy_s), .div_data_o(data_s), .div_ansok_o(ansok_s)
  );

  mdu_div #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .div_valid_i(valid), .div_opr1_i(opr1), .div_opr2_i(opr2),
    .div_flush_i(flush), .div_rdy_o(rdy_u), .div_data_o(data_u), .div_ansok_o(ansok_u)
  );

  // Reference: MIPS-style division with the divide-by-zero and overflow rules.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [31:0] q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge while the DUTs are ready; returns one falling edge after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1;
    opr1  = a;
    opr2  = b;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Walks cycles 0..33 after acceptance checking rdy/ansok/data timing and the final result.
  task automatic await_result(input logic [31:0] a, input logic [31:0] b, input bit chain,
                              input logic [31:0] na, input logic [31:0] nb, input bit noise);
    logic [63:0] es, eu;
    es = ref_div(a, b, 1'b1);
    eu = ref_div(a, b, 1'b0);
    for (int i = 0; i <= 33; i++) begin
      n_checks++;
      if (ansok_s !== (i == 33) || ansok_u !== (i == 33)) begin
        n_fail++;
        $display("FAIL ansok cyc%0d %h/%h: got s=%b u=%b expected %b", i, a, b, ansok_s, ansok_u, i == 33);
      end
      n_checks++;
      if (rdy_s !== (i == 33) || rdy_u !== (i == 33)) begin
        n_fail++;
        $display("FAIL rdy cyc%0d %h/%h: got s=%b u=%b expected %b", i, a, b, rdy_s, rdy_u, i == 33);
      end
      if (i < 33) begin
        n_checks++;
        if (data_s !== last_s || data_u !== last_u) begin
          n_fail++;
          $display("FAIL data_hold cyc%0d: got s=%h u=%h expected s=%h u=%h", i, data_s, data_u, last_s, last_u);
        end
      end else begin
        n_checks++;
        if (data_s !== es) begin
          n_fail++;
          $display("FAIL div %h/%h: got %h expected %h", a, b, data_s, es);
        end
        n_checks++;
        if (data_u !== eu) begin
          n_fail++;
          $display("FAIL divu %h/%h: got %h expected %h", a, b, data_u, eu);
        end
        last_s = es;
        last_u = eu;
      end
      if (noise && i == 5) begin
        valid = 1'b1;
        opr1  = $urandom;
        opr2  = $urandom;
      end
      if (noise && i == 6) valid = 1'b0;
      if (chain && i == 33) begin
        valid = 1'b1;
        opr1  = na;
        opr2  = nb;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    if (!chain) begin
      n_checks++;
      if (ansok_s !== 1'b0 || ansok_u !== 1'b0 || rdy_s !== 1'b1 || rdy_u !== 1'b1) begin
        n_fail++;
        $display("FAIL after_done %h/%h: got ansok s=%b u=%b rdy s=%b u=%b expected ansok 0 rdy 1",
                 a, b, ansok_s, ansok_u, rdy_s, rdy_u);
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b0;
    flush = 1'b0;
    opr1  = 32'h0;
    opr2  = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rdy_s !== 1'b1 || rdy_u !== 1'b1 || ansok_s !== 1'b0 || ansok_u !== 1'b0 ||
        data_s !== 64'h0 || data_u !== 64'h0) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b/%b ansok=%b/%b data=%h/%h expected 1 0 0",
               rdy_s, rdy_u, ansok_s, ansok_u, data_s, data_u);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
    logic [31:0] vb [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd16, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] xs [6] = '{64'h0000_0002_0000_000E, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_FFFF_FFFD,
                            64'hFFFF_FFFF_0000_0000, 64'h0000_0000_8000_0000, 64'h0000_0005_FFFF_FFFF};
    logic [63:0] xu [6] = '{64'h0000_0002_0000_000E, 64'h0000_0001_7FFF_FFFC, 64'h0000_0007_0000_0000,
                            64'h0000_000F_0FFF_FFFF, 64'h8000_0000_0000_0000, 64'h0000_0005_FFFF_FFFF};
    for (int k = 0; k < 6; k++) begin
      issue(va[k], vb[k]);
      await_result(va[k], vb[k], 1'b0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (data_s !== xs[k] || data_u !== xu[k]) begin
        n_fail++;
        $display("FAIL directed%0d: got s=%h u=%h expected s=%h u=%h", k, data_s, data_u, xs[k], xu[k]);
      end
    end
  endtask

  task automatic test_flush();
    issue(32'd9, 32'd3);
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    valid = 1'b1;
    opr1  = 32'd1;
    opr2  = 32'd1;
    @(negedge clk);
    flush = 1'b0;
    valid = 1'b0;
    n_checks++;
    if (rdy_s !== 1'b1 || rdy_u !== 1'b1 || ansok_s !== 1'b0 || ansok_u !== 1'b0 ||
        data_s !== last_s || data_u !== last_u) begin
      n_fail++;
      $display("FAIL flush: got rdy=%b/%b ansok=%b/%b data=%h/%h expected rdy 1 ansok 0 data %h/%h",
               rdy_s, rdy_u, ansok_s, ansok_u, data_s, data_u, last_s, last_u);
    end
    issue(32'd8, 32'd2);
    await_result(32'd8, 32'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (data_s !== 64'h0000_0000_0000_0004) begin
      n_fail++;
      $display("FAIL after_flush: got %h expected %h", data_s, 64'h0000_0000_0000_0004);
    end
  endtask

  task automatic test_back_to_back();
    issue(32'd20, 32'd3);
    await_result(32'd20, 32'd3, 1'b1, 32'd9, 32'd4, 1'b0);
    await_result(32'd9, 32'd4, 1'b0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (data_s !== 64'h0000_0001_0000_0002 || data_u !== 64'h0000_0001_0000_0002) begin
      n_fail++;
      $display("FAIL b2b: got s=%h u=%h expected %h", data_s, data_u, 64'h0000_0001_0000_0002);
    end
  endtask

  task automatic test_reset_mid();
    issue(32'd123, 32'd4);
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    flush = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    valid = 1'b0;
    n_checks++;
    if (rdy_s !== 1'b1 || rdy_u !== 1'b1 || ansok_s !== 1'b0 || ansok_u !== 1'b0 ||
        data_s !== 64'h0 || data_u !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b/%b ansok=%b/%b data=%h/%h expected 1 0 0",
               rdy_s, rdy_u, ansok_s, ansok_u, data_s, data_u);
    end
    last_s = 64'h0;
    last_u = 64'h0;
    issue(32'd77, 32'd5);
    await_result(32'd77, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int k = 0; k < 30; k++) begin
      a = pick_operand();
      b = pick_operand();
      issue(a, b);
      await_result(a, b, 1'b0, 32'h0, 32'h0, (k % 3) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
